// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX stage and muldiv_unit.
interface muldiv_if #(parameter int XLEN = 32);
   logic start, flush, busy, stall_req, done;
   logic [2:0] op;
   logic [XLEN-1:0] a, b, result;
   logic [4:0] rd_in, rd_out;
   modport master(output start, op, a, b, rd_in, flush, input busy, stall_req, done, result, rd_out);
   modport slave(input start, op, a, b, rd_in, flush, output busy, stall_req, done, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension execute unit (MUL*/DIV*/REM*)
// with an optional single-cycle multiplier and a registered, rd-tagged result.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter bit FAST_MUL = 1'b1
) (
   input logic clk,
   input logic rst,
   muldiv_if.slave io
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, DIV = 3'd2, FIX = 3'd3, DONE = 3'd4;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0] state, opr;
   logic [4:0] rd, rd_q;
   logic sa, sb, accept, a_neg, b_neg, dz, ovf, last, fits;
   logic [XLEN-1:0] m, hi, lo, ma, mb, special, res_q, fix_res;
   logic [CW-1:0] cnt;
   logic [XLEN:0] mul_sum, rem_sh;
   logic [2*XLEN-1:0] prod, prod_s;

   assign accept = io.start & ~io.flush & (state == IDLE | state == DONE);
   assign a_neg = io.a[XLEN-1] & (io.op[2] ? ~io.op[0] : io.op[1:0] != 2'b11);
   assign b_neg = io.b[XLEN-1] & (io.op[2] ? ~io.op[0] : ~io.op[1]);
   assign ma = a_neg ? -io.a : io.a;
   assign mb = b_neg ? -io.b : io.b;
   assign dz = io.b == '0;
   assign ovf = ~io.op[0] & (io.a == MOST_NEG) & (io.b == '1);
   assign special = io.op[1] ? (dz ? io.a : '0) : (dz ? '1 : MOST_NEG);
   assign last = cnt == CW'(XLEN - 1);
   // Both iterative paths work on magnitudes held in {hi, lo}; signs are restored in FIX.
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
   assign rem_sh = {hi, lo[XLEN-1]};
   assign fits = rem_sh >= {1'b0, m};
   assign prod = FAST_MUL ? {{XLEN{1'b0}}, m} * {{XLEN{1'b0}}, lo} : {hi, lo};
   assign prod_s = (sa ^ sb) ? -prod : prod;
   assign fix_res = opr[2] ? (opr[1] ? (sa ? -hi : hi) : ((sa ^ sb) ? -lo : lo))
                  : (opr[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

   assign io.busy = state == MUL | state == DIV | state == FIX;
   assign io.stall_req = accept | io.busy;
   assign io.done = state == DONE;
   assign io.result = res_q;
   assign io.rd_out = rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opr <= '0;
         rd <= '0;
         rd_q <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         m <= '0;
         hi <= '0;
         lo <= '0;
         cnt <= '0;
         res_q <= '0;
      end else if (io.flush) begin
         state <= IDLE;
      end else if (accept) begin
         opr <= io.op;
         rd <= io.rd_in;
         sa <= a_neg;
         sb <= b_neg;
         m <= io.op[2] ? mb : ma;
         lo <= io.op[2] ? ma : mb;
         hi <= '0;
         cnt <= '0;
         if (io.op[2] & (dz | ovf)) begin
            res_q <= special;
            rd_q <= io.rd_in;
            state <= DONE;
         end else begin
            state <= io.op[2] ? DIV : MUL;
         end
      end else if ((state == MUL && FAST_MUL) || state == FIX) begin
         res_q <= fix_res;
         rd_q <= rd;
         state <= DONE;
      end else if (state == MUL) begin
         {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
         cnt <= cnt + CW'(1);
         state <= last ? FIX : MUL;
      end else if (state == DIV) begin
         hi <= fits ? XLEN'(rem_sh - {1'b0, m}) : rem_sh[XLEN-1:0];
         lo <= {lo[XLEN-2:0], fits};
         cnt <= cnt + CW'(1);
         state <= last ? FIX : DIV;
      end else if (state == DONE) begin
         state <= IDLE;
      end
   end
endmodule
